display_scroll_controller: RTL and testbench
============================================

Name: display_scroll_controller

Overview:
Sequencing controller for the 4-digit seven-segment message display. It time-multiplexes the four active-low anodes, leaving blanking dead time between digits. It generates the character address for each digit from a 16-entry message store, and advances the message pointer on a debounced button press or an auto-scroll timer. Pointer updates occur only at frame boundaries, so a frame never shows a mix of old and new characters. The segment decoder and the message ROM sit downstream and consume char_addr.

Parameters:
SCAN_DIV, 16, clock cycles per digit slot (>= BLANK+2)
BLANK, 2, cycles at the start of each slot with all anodes off
DEBOUNCE, 8, consecutive stable synchronized samples required to accept a press or release
AUTO_FRAMES, 4, full frames between auto-scroll steps

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
button_move  input  1  raw asynchronous push-button, active-high
auto_en  input  1  enables auto-scroll
an3  output  1  anode digit 3 (leftmost), active-low
an2  output  1  anode digit 2, active-low
an1  output  1  anode digit 1, active-low
an0  output  1  anode digit 0 (rightmost), active-low
char_addr  output  4  message index for the currently scanned digit
pointer  output  4  message index shown on digit 3
step_pulse  output  1  one-cycle strobe when pointer changes

Behaviour:
- Reset values: an3..an0=1, char_addr=0, pointer=0, step_pulse=0, digit index=3, slot_cnt=0, frame_cnt=0, pending=0, debounce FSM=IDLE, sync flops=0.
- Scan:
  - slot_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index steps 3->2->1->0->3.
  - Frame = 4*SCAN_DIV cycles.
- Anodes are registered:
  - slot_cnt < BLANK: all four anodes = 1.
  - Otherwise: only the selected digit's anode = 0.
- char_addr is registered and loaded when slot_cnt==0, so it is stable through the blanking interval.
  - Value = (pointer + (3 - digit)) mod 16. Digit 3 shows pointer, digit 0 shows pointer+3.
  - 4-bit wrap: pointer 14 -> addresses 14, 15, 0, 1.
- Button path:
  - 2-flop synchronizer feeds the FSM.
  - FSM states:
    - IDLE: sync=1 -> CHK_PRESS with cnt=1.
    - CHK_PRESS: sync=1 increments cnt. On cnt==DEBOUNCE -> PRESSED and raise btn_req for one cycle. sync=0 -> IDLE.
    - PRESSED: sync=0 -> CHK_REL with cnt=1.
    - CHK_REL: sync=0 increments cnt. On cnt==DEBOUNCE -> IDLE. sync=1 -> PRESSED.
  - Exactly one request per accepted press. Holding the button never repeats.
- Auto path:
  - While auto_en=1, frame_cnt increments at each frame boundary.
  - On reaching AUTO_FRAMES it raises auto_req and clears to 0.
  - auto_en=0 holds frame_cnt at 0.
- Request merge:
  - pending <= pending | btn_req | auto_req.
  - Any number of requests within one frame, including simultaneous button and auto, collapse into a single step.
- Frame boundary is digit==0 and slot_cnt==SCAN_DIV-1. At that cycle, if pending:
  - pointer <= pointer+1 (mod 16, 15 -> 0);
  - pending <= 0;
  - step_pulse=1 for that single cycle.
  - A request arriving on the boundary cycle itself is applied at the next boundary.
- The new pointer is first visible in the char_addr loaded at the next digit-3 slot start, one cycle later.
- Synchronous reset mid-operation, on any cycle, restores all reset values on the next clock edge. Pending requests and in-progress debounce are discarded.

Test Plan:
- Reset: hold reset 15 cycles then release -> an=1111 and pointer=0 during reset. First active slot drives an3=0 at cycle BLANK=2 after release with char_addr=0. an2 goes low at cycle 18 with char_addr=1.
- Debounced press: button high 5 cycles then low -> no step_pulse and pointer stays 0. Button high 40 cycles -> exactly one step_pulse at the next frame boundary, and pointer=1.
- Held button: button high 1000 cycles -> pointer increments exactly once. Release for 20 cycles and press again for 20 cycles -> pointer=2.
- Auto-scroll: auto_en=1 with button idle -> step_pulse every 4 frames (256 cycles), pointer 0..15 then 15->0. Drop auto_en -> no further steps.
- Collision: button press accepted in the same frame as an auto request -> pointer advances by 1 only, with a single step_pulse.
- Wrap and reset: at pointer=14, check char_addr sequence 14,15,0,1 across one frame. Assert reset mid-slot with pending=1 -> next cycle all anodes=1, pointer=0, and no step_pulse afterwards.

Source files
------------

// File: rtl/display_scroll_controller.sv
// Scan sequencer for the 4-digit seven-segment message display: anode multiplexing
// with blanking, per-digit character addressing and frame-aligned message scrolling.
module display_scroll_controller #(
   parameter int unsigned SCAN_DIV    = 16,
   parameter int unsigned BLANK       = 2,
   parameter int unsigned DEBOUNCE    = 8,
   parameter int unsigned AUTO_FRAMES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button_move,
   input  logic       auto_en,
   output logic       an3,
   output logic       an2,
   output logic       an1,
   output logic       an0,
   output logic [3:0] char_addr,
   output logic [3:0] pointer,
   output logic       step_pulse
);

   localparam int unsigned SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W   = $clog2(DEBOUNCE + 1);
   localparam int unsigned FRAME_W = $clog2(AUTO_FRAMES + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHK_PRESS = 2'd1,
      PRESSED   = 2'd2,
      CHK_REL   = 2'd3
   } db_state_t;

   logic [SLOT_W-1:0]  slot_cnt;
   logic [1:0]         digit;
   logic [3:0]         an_q;
   logic [1:0]         sync_ff;
   db_state_t          db_state;
   logic [CNT_W-1:0]   db_cnt;
   logic               btn_req;
   logic [FRAME_W-1:0] frame_cnt;
   logic               auto_req;
   logic               pending;

   logic               slot_wrap_c;
   logic               frame_end_c;
   logic [SLOT_W-1:0]  slot_nxt_c;
   logic [1:0]         digit_nxt_c;
   logic               btn_sync_c;

   // Next scan position; anodes are decoded from it so they line up with slot_cnt.
   always_comb begin
      slot_wrap_c = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
      slot_nxt_c  = slot_wrap_c ? '0 : slot_cnt + SLOT_W'(1);
      digit_nxt_c = slot_wrap_c ? digit - 2'd1 : digit;
      frame_end_c = slot_wrap_c && (digit == 2'd0);
      btn_sync_c  = sync_ff[1];
   end

   assign an3 = an_q[3];
   assign an2 = an_q[2];
   assign an1 = an_q[1];
   assign an0 = an_q[0];

   // Slot/digit scan counters and anode drive.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt <= '0;
         digit    <= 2'd3;
         an_q     <= 4'b1111;
      end else begin
         slot_cnt <= slot_nxt_c;
         digit    <= digit_nxt_c;
         if (slot_nxt_c < SLOT_W'(BLANK))
            an_q <= 4'b1111;
         else
            an_q <= ~(4'(4'b0001 << digit_nxt_c));
      end
   end

   // Address latched at slot start; ~digit equals 3 - digit for a 2-bit index.
   always_ff @(posedge clk) begin
      if (reset)
         char_addr <= 4'd0;
      else if (slot_cnt == '0)
         char_addr <= pointer + {2'b00, ~digit};
   end

   // Two-flop synchronizer for the raw button.
   always_ff @(posedge clk) begin
      if (reset)
         sync_ff <= 2'b00;
      else
         sync_ff <= {sync_ff[0], button_move};
   end

   // Debounce FSM; db_cnt holds the number of consecutive stable samples seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_state <= IDLE;
         db_cnt   <= '0;
         btn_req  <= 1'b0;
      end else begin
         btn_req <= 1'b0;
         case (db_state)
            IDLE: begin
               if (btn_sync_c) begin
                  db_state <= CHK_PRESS;
                  db_cnt   <= CNT_W'(1);
               end
            end
            CHK_PRESS: begin
               if (!btn_sync_c) begin
                  db_state <= IDLE;
               end else if (db_cnt == CNT_W'(DEBOUNCE - 1)) begin
                  db_state <= PRESSED;
                  btn_req  <= 1'b1;
               end else begin
                  db_cnt <= db_cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!btn_sync_c) begin
                  db_state <= CHK_REL;
                  db_cnt   <= CNT_W'(1);
               end
            end
            CHK_REL: begin
               if (btn_sync_c) begin
                  db_state <= PRESSED;
               end else if (db_cnt == CNT_W'(DEBOUNCE - 1)) begin
                  db_state <= IDLE;
               end else begin
                  db_cnt <= db_cnt + CNT_W'(1);
               end
            end
            default: db_state <= IDLE;
         endcase
      end
   end

   // Auto-scroll frame counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         auto_req  <= 1'b0;
      end else begin
         auto_req <= 1'b0;
         if (!auto_en) begin
            frame_cnt <= '0;
         end else if (frame_end_c) begin
            if (frame_cnt == FRAME_W'(AUTO_FRAMES - 1)) begin
               frame_cnt <= '0;
               auto_req  <= 1'b1;
            end else begin
               frame_cnt <= frame_cnt + FRAME_W'(1);
            end
         end
      end
   end

   // Requests collapse into pending; a request on the boundary cycle waits a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         pointer    <= 4'd0;
         pending    <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         if (frame_end_c && pending) begin
            pointer    <= pointer + 4'd1;
            step_pulse <= 1'b1;
            pending    <= btn_req | auto_req;
         end else begin
            pending <= pending | btn_req | auto_req;
         end
      end
   end

endmodule

// File: tb/tb_display_scroll_controller.sv
// Directed bench for display_scroll_controller: step events are checked by a
// monitor against a queue of expected pointer values; scan outputs are spot-checked.
module tb_display_scroll_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       button_move;
   logic       auto_en;
   logic       an3, an2, an1, an0;
   logic [3:0] char_addr;
   logic [3:0] pointer;
   logic       step_pulse;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int base     = 0;
   int step_seen     = 0;
   int last_step_cyc = 0;
   int exp_q[$];
   int exp_ptr;

   display_scroll_controller dut (
      .clk        (clk),
      .reset      (reset),
      .button_move(button_move),
      .auto_en    (auto_en),
      .an3        (an3),
      .an2        (an2),
      .an1        (an1),
      .an0        (an0),
      .char_addr  (char_addr),
      .pointer    (pointer),
      .step_pulse (step_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every step_pulse must match the next queued pointer value.
   always @(negedge clk) begin
      if (reset === 1'b0 && step_pulse === 1'b1) begin
         step_seen++;
         last_step_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_step: step_pulse=1 with pointer=%0d at cycle %0d, expected no step",
                     pointer, cyc);
         end else begin
            exp_ptr = exp_q.pop_front();
            check("step_pointer", 32'(pointer), exp_ptr);
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic wait_step(input string name, input int start, input int budget);
      int n = 0;
      while (step_seen == start && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (step_seen == start) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: no step_pulse within %0d cycles, expected one", name, budget);
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      base  = cyc;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int prev;
      int b;
      reset       = 1'b1;
      button_move = 1'b0;
      auto_en     = 1'b0;

      // Reset state and first frame scan timing
      repeat (15) @(negedge clk);
      check("rst_an", 32'({an3, an2, an1, an0}), 4'b1111);
      check("rst_pointer", 32'(pointer), 0);
      check("rst_char_addr", 32'(char_addr), 0);
      check("rst_step", 32'(step_pulse), 0);
      reset = 1'b0;
      base  = cyc;
      wait_cyc(base + 1);
      check("blank_an", 32'({an3, an2, an1, an0}), 4'b1111);
      check("d3_addr", 32'(char_addr), 0);
      wait_cyc(base + 2);
      check("d3_an", 32'({an3, an2, an1, an0}), 4'b0111);
      wait_cyc(base + 17);
      check("d2_blank_an", 32'({an3, an2, an1, an0}), 4'b1111);
      check("d2_addr", 32'(char_addr), 1);
      wait_cyc(base + 18);
      check("d2_an", 32'({an3, an2, an1, an0}), 4'b1011);
      wait_cyc(base + 34);
      check("d1_an", 32'({an3, an2, an1, an0}), 4'b1101);
      check("d1_addr", 32'(char_addr), 2);
      wait_cyc(base + 50);
      check("d0_an", 32'({an3, an2, an1, an0}), 4'b1110);
      check("d0_addr", 32'(char_addr), 3);
      wait_cyc(base + 66);
      check("d3_again_an", 32'({an3, an2, an1, an0}), 4'b0111);
      check("d3_again_addr", 32'(char_addr), 0);

      // Short glitch rejected, long press accepted once
      button_move = 1'b1;
      repeat (5) @(negedge clk);
      button_move = 1'b0;
      repeat (150) @(negedge clk);
      check("glitch_pointer", 32'(pointer), 0);
      s = step_seen;
      exp_q.push_back(1);
      button_move = 1'b1;
      repeat (40) @(negedge clk);
      button_move = 1'b0;
      wait_step("press_step", s, 200);
      check("press_pointer", 32'(pointer), 1);

      // Held button steps once; a fresh press steps again
      do_reset(3);
      s = step_seen;
      exp_q.push_back(1);
      button_move = 1'b1;
      repeat (1000) @(negedge clk);
      check("held_steps", 32'(step_seen - s), 1);
      check("held_pointer", 32'(pointer), 1);
      button_move = 1'b0;
      repeat (20) @(negedge clk);
      s = step_seen;
      exp_q.push_back(2);
      button_move = 1'b1;
      repeat (20) @(negedge clk);
      button_move = 1'b0;
      wait_step("repress_step", s, 200);
      check("repress_pointer", 32'(pointer), 2);

      // Auto-scroll through a full wrap, with a char_addr wrap check at pointer 14
      do_reset(3);
      auto_en = 1'b1;
      s = step_seen;
      for (int i = 0; i < 16; i++) exp_q.push_back((i + 1) % 16);
      prev = 0;
      for (int i = 0; i < 16; i++) begin
         wait_step("auto_step", s + i, 400);
         if (i == 0)
            check("auto_first_cycle", 32'(last_step_cyc - base), 320);
         else
            check("auto_period", 32'(last_step_cyc - prev), 256);
         prev = last_step_cyc;
         if (i == 13) begin
            b = last_step_cyc;
            wait_cyc(b + 1);
            check("wrap_addr_d3", 32'(char_addr), 14);
            wait_cyc(b + 17);
            check("wrap_addr_d2", 32'(char_addr), 15);
            wait_cyc(b + 33);
            check("wrap_addr_d1", 32'(char_addr), 0);
            wait_cyc(b + 49);
            check("wrap_addr_d0", 32'(char_addr), 1);
         end
      end
      auto_en = 1'b0;
      s = step_seen;
      repeat (600) @(negedge clk);
      check("auto_off_steps", 32'(step_seen - s), 0);
      check("auto_wrap_pointer", 32'(pointer), 0);

      // Button press in the same frame as an auto request merges into one step
      do_reset(3);
      auto_en = 1'b1;
      s = step_seen;
      exp_q.push_back(1);
      wait_cyc(base + 265);
      button_move = 1'b1;
      wait_cyc(base + 305);
      button_move = 1'b0;
      wait_step("collision_step", s, 200);
      check("collision_cycle", 32'(last_step_cyc - base), 320);
      auto_en = 1'b0;
      repeat (400) @(negedge clk);
      check("collision_steps", 32'(step_seen - s), 1);
      check("collision_pointer", 32'(pointer), 1);

      // Mid-slot reset with a request pending discards it
      do_reset(3);
      wait_cyc(base + 5);
      button_move = 1'b1;
      wait_cyc(base + 25);
      button_move = 1'b0;
      wait_cyc(base + 30);
      check("pre_reset_an", 32'({an3, an2, an1, an0}), 4'b1011);
      reset = 1'b1;
      wait_cyc(base + 31);
      check("midrst_an", 32'({an3, an2, an1, an0}), 4'b1111);
      check("midrst_pointer", 32'(pointer), 0);
      check("midrst_char_addr", 32'(char_addr), 0);
      check("midrst_step", 32'(step_pulse), 0);
      reset = 1'b0;
      s = step_seen;
      repeat (200) @(negedge clk);
      check("midrst_no_step", 32'(step_seen - s), 0);
      check("midrst_pointer_after", 32'(pointer), 0);

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
